// File: rtl/alu_wb_ctrl_pkg.sv
// Shared constants for the ALU write-back sequencer: mode codes, opcode width, FSM encoding.
package alu_wb_ctrl_pkg;

    localparam int OPC_W = 3;

    localparam logic [1:0] MODE_LOGIC  = 2'b00;
    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_CRYPTO = 2'b10;
    localparam logic [1:0] MODE_ILL    = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WB_LO = 2'd2;
    localparam logic [1:0] ST_WB_HI = 2'd3;

    function automatic logic is_single_beat(input logic [1:0] mode);
        return mode == MODE_LOGIC;
    endfunction

endpackage

// File: rtl/alu_wb_ctrl_beat_mux.sv
// Write-back beat selector: picks address, data half and last flag from state, rd and result.
// Purely combinational; outputs idle at zero outside the two write-back states.
module wb_beat_mux
    import alu_wb_ctrl_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DATA_W = 16
) (
    input  logic [1:0]          state,
    input  logic [1:0]          mode,
    input  logic [REG_AW-1:0]   rd,
    input  logic [2*DATA_W-1:0] res,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_last
);

    always_comb begin
        wb_addr = '0;
        wb_data = '0;
        wb_last = 1'b0;
        case (state)
            ST_WB_LO: begin
                wb_addr = rd;
                wb_data = res[DATA_W-1:0];
                wb_last = is_single_beat(mode);
            end
            ST_WB_HI: begin
                // Upper half lands in the next register, wrapping at the top of the file.
                wb_addr = rd + REG_AW'(1);
                wb_data = res[2*DATA_W-1:DATA_W];
                wb_last = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_wb_ctrl.sv
// Issues one op to the external ALU, captures its result, and writes it back in one or two beats.
// Accept-to-first-beat is two cycles; no new issue until the last beat handshakes.
module alu_wb_ctrl
    import alu_wb_ctrl_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [DATA_W-1:0]   issue_a,
    input  logic [DATA_W-1:0]   issue_b,
    input  logic [OPC_W-1:0]    issue_opcode,
    input  logic [1:0]          issue_mode,
    input  logic [REG_AW-1:0]   issue_rd,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OPC_W-1:0]    alu_opcode,
    output logic [1:0]          alu_mode,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                alu_eq,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_last,
    output logic                eq_flag,
    output logic                err
);

    logic [1:0]          state_q,  state_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic [DATA_W-1:0]   b_q,      b_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [1:0]          mode_q,   mode_d;
    logic [REG_AW-1:0]   rd_q,     rd_d;
    logic [2*DATA_W-1:0] res_q,    res_d;
    logic                eq_q,     eq_d;
    logic                err_q,    err_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        mode_d   = mode_q;
        rd_d     = rd_q;
        res_d    = res_q;
        eq_d     = eq_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    a_d      = issue_a;
                    b_d      = issue_b;
                    opcode_d = issue_opcode;
                    mode_d   = issue_mode;
                    rd_d     = issue_rd;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d = alu_out;
                eq_d  = alu_eq;
                if (mode_q == MODE_ILL) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WB_LO;
                end
            end
            ST_WB_LO: begin
                if (wb_ready) begin
                    state_d = is_single_beat(mode_q) ? ST_IDLE : ST_WB_HI;
                end
            end
            ST_WB_HI: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset mode is illegal so the attached ALU idles with a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            mode_q   <= MODE_ILL;
            rd_q     <= '0;
            res_q    <= '0;
            eq_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opcode_q <= opcode_d;
            mode_q   <= mode_d;
            rd_q     <= rd_d;
            res_q    <= res_d;
            eq_q     <= eq_d;
            err_q    <= err_d;
        end
    end

    assign issue_ready = (state_q == ST_IDLE);
    assign wb_valid    = (state_q == ST_WB_LO) || (state_q == ST_WB_HI);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = opcode_q;
    assign alu_mode    = mode_q;
    assign eq_flag     = eq_q;
    assign err         = err_q;

    wb_beat_mux #(
        .REG_AW (REG_AW),
        .DATA_W (DATA_W)
    ) u_beat_mux (
        .state   (state_q),
        .mode    (mode_q),
        .rd      (rd_q),
        .res     (res_q),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .wb_last (wb_last)
    );

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Directed bench for alu_wb_ctrl with a stubbed ALU driven from the bench.
module tb_alu_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] issue_a, issue_b;
    logic [2:0]  issue_opcode;
    logic [1:0]  issue_mode;
    logic [3:0]  issue_rd;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [1:0]  alu_mode;
    logic [31:0] alu_out;
    logic        alu_eq;
    logic        wb_valid, wb_ready, wb_last;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        eq_flag, err;

    logic        stub_model;
    logic [31:0] alu_stub;
    logic        eq_stub;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    // Stub ALU: either a fixed value, or {b, a} with a==b as the equality flag.
    assign alu_out = stub_model ? {alu_b, alu_a} : alu_stub;
    assign alu_eq  = stub_model ? (alu_a == alu_b) : eq_stub;

    always @(posedge clk) begin
        if (!rst && issue_valid && issue_ready) acc_cnt <= acc_cnt + 1;
        if (!rst && wb_valid && wb_ready && wb_last) last_cnt <= last_cnt + 1;
    end

    alu_wb_ctrl #(.REG_AW(4), .DATA_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .issue_opcode (issue_opcode),
        .issue_mode   (issue_mode),
        .issue_rd     (issue_rd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_mode     (alu_mode),
        .alu_out      (alu_out),
        .alu_eq       (alu_eq),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_last      (wb_last),
        .eq_flag      (eq_flag),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for exactly one edge; caller ensures issue_ready is high.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] mode,
                         input logic [3:0] rd);
        issue_a = a; issue_b = b; issue_mode = mode; issue_rd = rd; issue_opcode = 3'd5;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", issue_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
        checks++; if ({alu_a, alu_b, alu_opcode, alu_mode} !== {16'h0, 16'h0, 3'd0, 2'b11}) begin
            errors++; $display("FAIL rst_alu_regs got %h %h %h %b want 0 0 0 11", alu_a, alu_b, alu_opcode, alu_mode); end
        checks++; if ({wb_addr, wb_data, wb_last, eq_flag, err} !== 23'h0) begin
            errors++; $display("FAIL rst_outputs got addr %h data %h last %b eq %b err %b want zeros", wb_addr, wb_data, wb_last, eq_flag, err); end
    endtask

    task automatic test_logic();
        alu_stub = 32'h0000_0FFF; eq_stub = 1'b0; wb_ready = 1'b1;
        issue(16'h00F0, 16'h0F0F, 2'b00, 4'd3);
        checks++; if ({wb_valid, issue_ready} !== 2'b00) begin errors++; $display("FAIL logic_exec got valid %b ready %b want 0 0", wb_valid, issue_ready); end
        checks++; if ({alu_a, alu_b, alu_mode, alu_opcode} !== {16'h00F0, 16'h0F0F, 2'b00, 3'd5}) begin
            errors++; $display("FAIL logic_alu_regs got %h %h %b %h", alu_a, alu_b, alu_mode, alu_opcode); end
        tick();
        checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, 4'd3, 16'h0FFF, 1'b1}) begin
            errors++; $display("FAIL logic_beat got v%b a%h d%h l%b want v1 a3 d0fff l1", wb_valid, wb_addr, wb_data, wb_last); end
        tick();
        checks++; if ({wb_valid, issue_ready} !== 2'b01) begin errors++; $display("FAIL logic_done got valid %b ready %b want 0 1", wb_valid, issue_ready); end
    endtask

    task automatic test_arith();
        alu_stub = 32'h0001_E240; wb_ready = 1'b1;
        issue(16'd100, 16'd1234, 2'b01, 4'd6);
        tick();
        checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, 4'd6, 16'hE240, 1'b0}) begin
            errors++; $display("FAIL arith_lo got v%b a%h d%h l%b want v1 a6 de240 l0", wb_valid, wb_addr, wb_data, wb_last); end
        tick();
        checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, 4'd7, 16'h0001, 1'b1}) begin
            errors++; $display("FAIL arith_hi got v%b a%h d%h l%b want v1 a7 d0001 l1", wb_valid, wb_addr, wb_data, wb_last); end
        tick();
        checks++; if ({wb_valid, issue_ready} !== 2'b01) begin errors++; $display("FAIL arith_done got valid %b ready %b want 0 1", wb_valid, issue_ready); end
    endtask

    task automatic test_stall();
        alu_stub = 32'hDEAD_BEEF; wb_ready = 1'b0;
        issue(16'h1111, 16'h2222, 2'b10, 4'd15);
        tick();
        alu_stub = 32'h5555_AAAA;  // result must already be captured
        for (int i = 0; i < 3; i++) begin
            checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, 4'd15, 16'hBEEF, 1'b0}) begin
                errors++; $display("FAIL stall_lo[%0d] got v%b a%h d%h l%b want v1 af dbeef l0", i, wb_valid, wb_addr, wb_data, wb_last); end
            if (i < 2) tick();
        end
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, 4'd0, 16'hDEAD, 1'b1}) begin
                errors++; $display("FAIL stall_hi[%0d] got v%b a%h d%h l%b want v1 a0 ddead l1", i, wb_valid, wb_addr, wb_data, wb_last); end
            checks++; if ({alu_a, alu_mode} !== {16'h1111, 2'b10}) begin
                errors++; $display("FAIL stall_alu_hold[%0d] got %h %b want 1111 10", i, alu_a, alu_mode); end
            if (i < 2) tick();
        end
        wb_ready = 1'b1; tick();
        checks++; if ({wb_valid, issue_ready} !== 2'b01) begin errors++; $display("FAIL stall_done got valid %b ready %b want 0 1", wb_valid, issue_ready); end
    endtask

    task automatic test_illegal();
        alu_stub = 32'h0; eq_stub = 1'b1; wb_ready = 1'b1;
        issue(16'h4, 16'h4, 2'b11, 4'd2);
        checks++; if ({err, wb_valid} !== 2'b00) begin errors++; $display("FAIL ill_exec got err %b valid %b want 0 0", err, wb_valid); end
        tick();
        checks++; if ({err, wb_valid, eq_flag, issue_ready} !== 4'b1011) begin
            errors++; $display("FAIL ill_pulse got err %b valid %b eq %b ready %b want 1 0 1 1", err, wb_valid, eq_flag, issue_ready); end
        tick();
        checks++; if ({err, wb_valid, eq_flag} !== 3'b001) begin
            errors++; $display("FAIL ill_after got err %b valid %b eq %b want 0 0 1", err, wb_valid, eq_flag); end
    endtask

    task automatic test_reset_mid();
        alu_stub = 32'h1234_5678; eq_stub = 1'b1; wb_ready = 1'b1;
        issue(16'h9, 16'h9, 2'b01, 4'd9);
        tick(); tick();
        checks++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 4'd10, 16'h1234}) begin
            errors++; $display("FAIL rmid_hi got v%b a%h d%h want v1 aa d1234", wb_valid, wb_addr, wb_data); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if ({wb_valid, wb_addr, wb_data, wb_last, eq_flag, err, issue_ready} !== {1'b0, 4'd0, 16'h0, 4'b0001}) begin
            errors++; $display("FAIL rmid_outputs got v%b a%h d%h l%b eq%b err%b rdy%b", wb_valid, wb_addr, wb_data, wb_last, eq_flag, err, issue_ready); end
        checks++; if ({alu_a, alu_b, alu_opcode, alu_mode} !== {16'h0, 16'h0, 3'd0, 2'b11}) begin
            errors++; $display("FAIL rmid_alu_regs got %h %h %h %b want 0 0 0 11", alu_a, alu_b, alu_opcode, alu_mode); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_beat got %b want 0", wb_valid); end
        alu_stub = 32'h0000_AAAA; eq_stub = 1'b0;
        issue(16'hA, 16'hB, 2'b00, 4'd5);
        tick();
        checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, 4'd5, 16'hAAAA, 1'b1}) begin
            errors++; $display("FAIL rmid_fresh got v%b a%h d%h l%b want v1 a5 daaaa l1", wb_valid, wb_addr, wb_data, wb_last); end
        tick();
        checks++; if ({wb_valid, issue_ready} !== 2'b01) begin errors++; $display("FAIL rmid_done got valid %b ready %b want 0 1", wb_valid, issue_ready); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4] = '{16'h0005, 16'h1234, 16'h0007, 16'hAAAA};
        logic [15:0] vb [4] = '{16'h0005, 16'h4321, 16'h0007, 16'h0000};
        logic [1:0]  vm [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [3:0]  vr [4] = '{4'd1, 4'd14, 4'd15, 4'd4};
        int acc0, last0, waited;
        stub_model = 1'b1; wb_ready = 1'b1;
        acc0 = acc_cnt; last0 = last_cnt;
        issue_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue_a = va[k]; issue_b = vb[k]; issue_mode = vm[k]; issue_rd = vr[k];
            waited = 0;
            while (!issue_ready && waited < 10) begin tick(); waited++; end
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", k, issue_ready); end
            tick();
            checks++; if ({alu_a, alu_b} !== {va[k], vb[k]}) begin
                errors++; $display("FAIL b2b_accept[%0d] got %h %h want %h %h", k, alu_a, alu_b, va[k], vb[k]); end
            tick();
            checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, vr[k], va[k], vm[k] == 2'b00}) begin
                errors++; $display("FAIL b2b_lo[%0d] got v%b a%h d%h l%b", k, wb_valid, wb_addr, wb_data, wb_last); end
            checks++; if (eq_flag !== (va[k] == vb[k])) begin
                errors++; $display("FAIL b2b_eq[%0d] got %b want %b", k, eq_flag, va[k] == vb[k]); end
            if (vm[k] != 2'b00) begin
                tick();
                checks++; if ({wb_valid, wb_addr, wb_data, wb_last} !== {1'b1, vr[k] + 4'd1, vb[k], 1'b1}) begin
                    errors++; $display("FAIL b2b_hi[%0d] got v%b a%h d%h l%b", k, wb_valid, wb_addr, wb_data, wb_last); end
            end
            tick();
        end
        issue_valid = 1'b0;
        tick(); tick();
        checks++; if (acc_cnt - acc0 !== 4) begin errors++; $display("FAIL b2b_accepts got %0d want 4", acc_cnt - acc0); end
        checks++; if (last_cnt - last0 !== 4) begin errors++; $display("FAIL b2b_completions got %0d want 4", last_cnt - last0); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_quiet got %b want 0", wb_valid); end
        stub_model = 1'b0;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_a = '0; issue_b = '0; issue_opcode = '0;
        issue_mode = '0; issue_rd = '0; wb_ready = 1'b0;
        stub_model = 1'b0; alu_stub = '0; eq_stub = 1'b0;
        test_reset();
        test_logic();
        test_arith();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

endmodule
